// File: rtl/fifo_wr_arbiter.sv
// Write-side arbiter in front of an async FIFO: round-robin between NREQ requesters,
// bursts of up to BURST words per owner, stalls on full/almost-full, registered write port.
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8,
    parameter int BURST = 4
) (
    input  logic                    wclk,
    input  logic                    wrst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*DSIZE-1:0]   wdata_in,
    input  logic                    wfull,
    input  logic                    afull_n,
    output logic [NREQ-1:0]         gnt,
    output logic                    winc,
    output logic [DSIZE-1:0]        wdata,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    busy
);

    localparam int OW = $clog2(NREQ);
    localparam int CW = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BURST = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;

    localparam logic [OW-1:0] LAST_IDX = OW'(NREQ - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(BURST);

    // First requester at or after start, wrapping; MSB flags that a winner exists.
    function automatic logic [OW:0] pick_first(input logic [NREQ-1:0] r, input logic [OW-1:0] start);
        logic [OW-1:0] hi_idx;
        logic [OW-1:0] lo_idx;
        logic          hi_hit;
        logic          lo_hit;
        hi_idx = {OW{1'b0}};
        lo_idx = {OW{1'b0}};
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (r[i]) begin
                lo_hit = 1'b1;
                lo_idx = OW'(i);
                if (OW'(i) >= start) begin
                    hi_hit = 1'b1;
                    hi_idx = OW'(i);
                end
            end
        end
        return hi_hit ? {1'b1, hi_idx} : {lo_hit, lo_idx};
    endfunction

    logic [1:0]       state_r;
    logic [1:0]       state_n_s;
    logic [OW-1:0]    rr_ptr_r;
    logic [OW-1:0]    rr_ptr_n_s;
    logic [OW-1:0]    owner_r;
    logic [OW-1:0]    owner_n_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_n_s;
    logic             winc_r;
    logic [DSIZE-1:0] wdata_r;
    logic             busy_r;

    logic             blocked_s;
    logic             own_req_s;
    logic [OW-1:0]    rel_ptr_s;
    logic [OW:0]      idle_pick_s;
    logic [OW:0]      rel_pick_s;
    logic             take_s;
    logic [OW-1:0]    take_idx_s;
    logic [NREQ-1:0]  gnt_s;
    logic [DSIZE-1:0] gword_s;

    assign blocked_s   = wfull | ~afull_n;
    assign own_req_s   = req[owner_r];
    assign rel_ptr_s   = (owner_r == LAST_IDX) ? {OW{1'b0}} : owner_r + OW'(1);
    assign idle_pick_s = pick_first(req, rr_ptr_r);
    assign rel_pick_s  = pick_first(req, rel_ptr_s);

    // Next-state, grant decision and pointer/counter updates.
    always_comb begin
        state_n_s  = state_r;
        owner_n_s  = owner_r;
        cnt_n_s    = cnt_r;
        rr_ptr_n_s = rr_ptr_r;
        take_s     = 1'b0;
        take_idx_s = owner_r;
        case (state_r)
            ST_IDLE: begin
                if (idle_pick_s[OW] && !blocked_s) begin
                    take_s     = 1'b1;
                    take_idx_s = idle_pick_s[OW-1:0];
                    owner_n_s  = idle_pick_s[OW-1:0];
                    cnt_n_s    = 4'd1;
                    state_n_s  = ST_BURST;
                end else begin
                    state_n_s  = ST_IDLE;
                end
            end
            // STALL is only entered with cnt below BURST, so both states share the same rules.
            ST_BURST, ST_STALL: begin
                if (own_req_s && (cnt_r < CNT_MAX)) begin
                    if (!blocked_s) begin
                        take_s    = 1'b1;
                        cnt_n_s   = cnt_r + 4'd1;
                        state_n_s = ST_BURST;
                    end else begin
                        state_n_s = ST_STALL;
                    end
                end else begin
                    rr_ptr_n_s = rel_ptr_s;
                    if (rel_pick_s[OW] && !blocked_s) begin
                        take_s     = 1'b1;
                        take_idx_s = rel_pick_s[OW-1:0];
                        owner_n_s  = rel_pick_s[OW-1:0];
                        cnt_n_s    = 4'd1;
                        state_n_s  = ST_BURST;
                    end else begin
                        cnt_n_s    = 4'd0;
                        state_n_s  = ST_IDLE;
                    end
                end
            end
            default: begin
                cnt_n_s   = 4'd0;
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // One-hot accept, forced low during reset, and the matching data word.
    always_comb begin
        gnt_s   = {NREQ{1'b0}};
        gword_s = {DSIZE{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            gnt_s[i] = take_s & ~wrst & (take_idx_s == OW'(i));
            gword_s  = gword_s | (wdata_in[i*DSIZE +: DSIZE] & {DSIZE{gnt_s[i]}});
        end
    end

    // State registers and the registered FIFO write port.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state_r  <= ST_IDLE;
            rr_ptr_r <= {OW{1'b0}};
            owner_r  <= {OW{1'b0}};
            cnt_r    <= 4'd0;
            winc_r   <= 1'b0;
            wdata_r  <= {DSIZE{1'b0}};
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_n_s;
            rr_ptr_r <= rr_ptr_n_s;
            owner_r  <= owner_n_s;
            cnt_r    <= cnt_n_s;
            winc_r   <= |gnt_s;
            wdata_r  <= (|gnt_s) ? gword_s : wdata_r;
            busy_r   <= (state_n_s != ST_IDLE);
        end
    end

    assign gnt   = gnt_s;
    assign winc  = winc_r;
    assign wdata = wdata_r;
    assign owner = owner_r;
    assign busy  = busy_r;

endmodule
